// File: rtl/ferry_planner.sv
// Ferry planner: issues the wolf/goat/cabbage crossing plan over a valid/ready
// handshake, mirrors all four bank positions and flags any unsafe bank state.
module ferry_planner #(
    parameter bit ALT_ORDER = 1'b0,
    parameter int STEP_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              move_ready,
    output logic              move_valid,
    output logic              move_w,
    output logic              move_g,
    output logic              move_c,
    output logic [STEP_W-1:0] step,
    output logic              bank_m,
    output logic              bank_w,
    output logic              bank_g,
    output logic              bank_c,
    output logic              busy,
    output logic              done,
    output logic              violation
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [STEP_W-1:0] step_next;
    logic              m_next;
    logic              w_next;
    logic              g_next;
    logic              c_next;
    logic              violation_next;
    logic              plan_w;
    logic              plan_g;
    logic              plan_c;
    logic              accept;
    logic              unsafe;
    logic [2:0]        plan_idx;

    // The plan has only seven entries, so the low three step bits select the move.
    assign plan_idx = step[2:0];

    always_comb begin
        plan_w = 1'b0;
        plan_g = 1'b0;
        plan_c = 1'b0;
        case (plan_idx)
            3'd0, 3'd3, 3'd6: plan_g = 1'b1;
            3'd2: begin
                if (ALT_ORDER) plan_c = 1'b1;
                else           plan_w = 1'b1;
            end
            3'd4: begin
                if (ALT_ORDER) plan_w = 1'b1;
                else           plan_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign move_valid = (state == ISSUE);
    assign busy       = (state == ISSUE);
    assign done       = (state == DONE);
    assign move_w     = move_valid & plan_w;
    assign move_g     = move_valid & plan_g;
    assign move_c     = move_valid & plan_c;
    assign accept     = move_valid & move_ready;

    assign unsafe = ((bank_w == bank_g) & (bank_g != bank_m)) |
                    ((bank_g == bank_c) & (bank_g != bank_m));

    always_comb begin
        state_next     = state;
        step_next      = step;
        m_next         = bank_m;
        w_next         = bank_w;
        g_next         = bank_g;
        c_next         = bank_c;
        violation_next = violation | unsafe;
        case (state)
            IDLE, DONE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next     = ISSUE;
                    step_next      = '0;
                    m_next         = 1'b0;
                    w_next         = 1'b0;
                    g_next         = 1'b0;
                    c_next         = 1'b0;
                    violation_next = 1'b0;
                end
            end
            ISSUE: begin
                // Abort wins over a same-cycle accept: nothing moves.
                if (abort) begin
                    state_next = IDLE;
                end else if (accept) begin
                    m_next    = ~bank_m;
                    step_next = step + STEP_W'(1);
                    if (plan_w) w_next = ~bank_m;
                    if (plan_g) g_next = ~bank_m;
                    if (plan_c) c_next = ~bank_m;
                    if (step == STEP_W'(6)) state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            bank_m    <= 1'b0;
            bank_w    <= 1'b0;
            bank_g    <= 1'b0;
            bank_c    <= 1'b0;
            violation <= 1'b0;
        end else begin
            state     <= state_next;
            step      <= step_next;
            bank_m    <= m_next;
            bank_w    <= w_next;
            bank_g    <= g_next;
            bank_c    <= c_next;
            violation <= violation_next;
        end
    end

endmodule

// File: tb/tb_ferry_planner.sv
// Directed bench for ferry_planner: both plan orders side by side, stalls,
// abort, held start and asynchronous reset.
module tb_ferry_planner;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       move_ready;

    logic       move_valid0, move_w0, move_g0, move_c0;
    logic [2:0] step0;
    logic       bank_m0, bank_w0, bank_g0, bank_c0, busy0, done0, violation0;
    logic       move_valid1, move_w1, move_g1, move_c1;
    logic [2:0] step1;
    logic       bank_m1, bank_w1, bank_g1, bank_c1, busy1, done1, violation1;

    logic [3:0] banks0, banks1;
    logic [2:0] mv0, mv1;

    int total = 0;
    int bad   = 0;

    // Moves encoded as {w,g,c}.
    logic [2:0] plan0 [7] = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b010};
    logic [2:0] plan1 [7] = '{3'b010, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b010};

    assign banks0 = {bank_m0, bank_w0, bank_g0, bank_c0};
    assign banks1 = {bank_m1, bank_w1, bank_g1, bank_c1};
    assign mv0    = {move_w0, move_g0, move_c0};
    assign mv1    = {move_w1, move_g1, move_c1};

    ferry_planner #(.ALT_ORDER(1'b0), .STEP_W(3)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .move_ready(move_ready),
        .move_valid(move_valid0), .move_w(move_w0), .move_g(move_g0), .move_c(move_c0),
        .step(step0), .bank_m(bank_m0), .bank_w(bank_w0), .bank_g(bank_g0),
        .bank_c(bank_c0), .busy(busy0), .done(done0), .violation(violation0)
    );

    ferry_planner #(.ALT_ORDER(1'b1), .STEP_W(3)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .move_ready(move_ready),
        .move_valid(move_valid1), .move_w(move_w1), .move_g(move_g1), .move_c(move_c1),
        .step(step1), .bank_m(bank_m1), .bank_w(bank_w1), .bank_g(bank_g1),
        .bank_c(bank_c1), .busy(busy1), .done(done1), .violation(violation1)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; move_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({move_valid0, busy0, done0, violation0} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b want 0000", {move_valid0, busy0, done0, violation0});
        end
        total++;
        if (step0 !== 3'd0) begin
            bad++;
            $display("[TB] FAIL reset_step: got %0d want 0", step0);
        end
        total++;
        if (banks0 !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_banks: got %b want 0000", banks0);
        end
        total++;
        if (mv0 !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_moves: got %b want 000", mv0);
        end
    endtask

    task automatic test_plan_run();
        @(negedge clk);
        start = 1'b1; move_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            start = 1'b0;
            total++;
            if ({move_valid0, mv0} !== {1'b1, plan0[i]}) begin
                bad++;
                $display("[TB] FAIL run0_move step%0d: got %b want %b", i, {move_valid0, mv0}, {1'b1, plan0[i]});
            end
            total++;
            if (step0 !== 3'(i)) begin
                bad++;
                $display("[TB] FAIL run0_step: got %0d want %0d", step0, i);
            end
            total++;
            if ({move_valid1, mv1} !== {1'b1, plan1[i]}) begin
                bad++;
                $display("[TB] FAIL run1_move step%0d: got %b want %b", i, {move_valid1, mv1}, {1'b1, plan1[i]});
            end
            if (i == 4) begin
                total++;
                if (banks0 !== 4'b0100) begin
                    bad++;
                    $display("[TB] FAIL run0_banks_after3: got %b want 0100", banks0);
                end
            end
            if (i == 5) begin
                total++;
                if (banks1 !== 4'b1101) begin
                    bad++;
                    $display("[TB] FAIL run1_banks_after4: got %b want 1101", banks1);
                end
            end
        end
        @(negedge clk);
        total++;
        if ({done0, move_valid0, violation0, step0, banks0} !== {1'b1, 1'b0, 1'b0, 3'd7, 4'b1111}) begin
            bad++;
            $display("[TB] FAIL run0_done: got %b want 1001111111", {done0, move_valid0, violation0, step0, banks0});
        end
        total++;
        if ({done1, move_valid1, violation1, step1, banks1} !== {1'b1, 1'b0, 1'b0, 3'd7, 4'b1111}) begin
            bad++;
            $display("[TB] FAIL run1_done: got %b want 1001111111", {done1, move_valid1, violation1, step1, banks1});
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if ({done0, busy0, move_valid0, banks0} !== {3'b000, 4'b1111}) begin
            bad++;
            $display("[TB] FAIL done_abort: got %b want 0001111", {done0, busy0, move_valid0, banks0});
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        start = 1'b1; move_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        move_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({move_valid0, busy0, mv0, step0} !== {1'b1, 1'b1, 3'b100, 3'd2}) begin
                bad++;
                $display("[TB] FAIL stall_hold cycle%0d: got %b want 111002", k, {move_valid0, busy0, mv0, step0});
            end
            @(negedge clk);
        end
        move_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({step0, banks0} !== {3'd3, 4'b1110}) begin
            bad++;
            $display("[TB] FAIL stall_release: got step=%0d banks=%b want step=3 banks=1110", step0, banks0);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_abort_accept();
        @(negedge clk);
        start = 1'b1; move_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if ({step0, banks0} !== {3'd4, 4'b0100}) begin
            bad++;
            $display("[TB] FAIL abort_pre: got step=%0d banks=%b want step=4 banks=0100", step0, banks0);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if ({move_valid0, busy0, done0, step0, banks0} !== {3'b000, 3'd4, 4'b0100}) begin
            bad++;
            $display("[TB] FAIL abort_hold: got %b want 0001000100", {move_valid0, busy0, done0, step0, banks0});
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({move_valid0, mv0, step0, banks0} !== {1'b1, 3'b010, 3'd0, 4'b0000}) begin
            bad++;
            $display("[TB] FAIL abort_replay: got %b want 10100000000", {move_valid0, mv0, step0, banks0});
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_start_held();
        @(negedge clk);
        start = 1'b1; move_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            total++;
            if ({move_valid0, step0} !== {1'b1, 3'(i)}) begin
                bad++;
                $display("[TB] FAIL held_issue: got valid=%b step=%0d want valid=1 step=%0d", move_valid0, step0, i);
            end
        end
        @(negedge clk);
        total++;
        if ({done0, step0, banks0, violation0} !== {1'b1, 3'd7, 4'b1111, 1'b0}) begin
            bad++;
            $display("[TB] FAIL held_done: got %b want 111111110", {done0, step0, banks0, violation0});
        end
        @(negedge clk);
        total++;
        if ({done0, move_valid0, step0, banks0} !== {1'b0, 1'b1, 3'd0, 4'b0000}) begin
            bad++;
            $display("[TB] FAIL held_restart: got %b want 010000000", {done0, move_valid0, step0, banks0});
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; move_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        move_ready = 1'b0;
        total++;
        if ({move_valid0, step0} !== {1'b1, 3'd3}) begin
            bad++;
            $display("[TB] FAIL rstmid_pre: got valid=%b step=%0d want valid=1 step=3", move_valid0, step0);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({move_valid0, busy0, done0, step0, banks0} !== {3'b000, 3'd0, 4'b0000}) begin
            bad++;
            $display("[TB] FAIL rstmid_async: got %b want 0000000000", {move_valid0, busy0, done0, step0, banks0});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_plan_run();
        test_stall();
        test_abort_accept();
        test_start_held();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
